// File: rtl/axi_perceptron_n_if.sv
// AXI4-Lite bus bundle for the axi_perceptron_n peripheral.
// The slave modport is used by the perceptron. The master modport is used by whatever drives it.
interface axi_perceptron_n_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_perceptron_n.sv
// AXI4-Lite perceptron: computes bias + sum(x[i]*w[i]) with a sequential
// MAC engine that handles one term per cycle. The result is saturated to
// 32 bits and drives a step activation output.
// The optional interrupt output is enabled by defining AXI_PERCEPTRON_IRQ_EN.
module axi_perceptron_n #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_INPUTS           = 8,
    parameter int OPERAND_WIDTH      = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi_perceptron_n_if.slave    s_axi,
    output logic                 perceptron_out
`ifdef AXI_PERCEPTRON_IRQ_EN
    ,
    output logic                 irq
`endif
);
    localparam int OW    = OPERAND_WIDTH;
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int ACC_W = 2 * OW + $clog2(N_INPUTS) + 33;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN} state_e;
    typedef enum logic [2:0] {R_CTRL, R_STATUS, R_BIAS, R_RESULT, R_X, R_W, R_NONE} reg_kind_e;
    typedef struct packed {
        reg_kind_e  kind;
        logic [3:0] idx;
    } reg_sel_t;

    state_e             state;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   acc;
    logic [31:0]        bias_q;
    logic [31:0]        result_q;
    logic [OW-1:0]      x_q [N_INPUTS];
    logic [OW-1:0]      w_q [N_INPUTS];
    logic               busy;
    logic               done;
    logic               ovf;
`ifdef AXI_PERCEPTRON_IRQ_EN
    logic               irq_en;
`endif

    // Map a byte address onto a register kind and an X/W index.
    function automatic reg_sel_t decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        reg_sel_t   sel;
        logic [7:0] off;
        // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
        off      = addr[7:0];
        sel.kind = R_NONE;
        sel.idx  = off[5:2];
        if ((addr >> 8) == '0) begin
            case (off[7:6])
                2'b00: begin
                    case (off[5:2])
                        4'd0:    sel.kind = R_CTRL;
                        4'd1:    sel.kind = R_STATUS;
                        4'd2:    sel.kind = R_BIAS;
                        4'd3:    sel.kind = R_RESULT;
                        default: sel.kind = R_NONE;
                    endcase
                end
                2'b01:   if ({1'b0, off[5:2]} < 5'(N_INPUTS)) sel.kind = R_X;
                2'b10:   if ({1'b0, off[5:2]} < 5'(N_INPUTS)) sel.kind = R_W;
                default: sel.kind = R_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] sext(input logic [OW-1:0] v);
        return {{(32-OW){v[OW-1]}}, v};
    endfunction

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    reg_sel_t           wsel;
    reg_sel_t           rsel;
    logic [IDX_W-1:0]   widx;
    logic [IDX_W-1:0]   ridx;
    logic               wr_fire;
    logic               rd_fire;
    logic [2*OW-1:0]    prod;
    logic [ACC_W-32:0]  acc_hi;
    logic [31:0]        sat_val;
    logic               sat_clamp;
    logic               unused_ok;

    assign wsel    = decode(s_axi.awaddr);
    assign rsel    = decode(s_axi.araddr);
    assign widx    = wsel.idx[IDX_W-1:0];
    assign ridx    = rsel.idx[IDX_W-1:0];
    assign wr_fire = s_axi.awready && s_axi.awvalid && s_axi.wvalid;
    assign rd_fire = s_axi.arready && s_axi.arvalid;
    assign prod    = $signed(x_q[idx]) * $signed(w_q[idx]);

    // The accumulator fits in 32 bits only when every bit from 31 upward equals the sign.
    assign acc_hi    = acc[ACC_W-1:31];
    assign sat_clamp = !((&acc_hi) || !(|acc_hi));
    assign sat_val   = !sat_clamp ? acc[31:0] :
                       (acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         wsel.idx, rsel.idx};

    // Write channel, register file and MAC sequencer share one block because START and the FSM both own BUSY, DONE and OVF.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi.awready  <= 1'b0;
            s_axi.wready   <= 1'b0;
            s_axi.bvalid   <= 1'b0;
            s_axi.bresp    <= RESP_OKAY;
            state          <= S_IDLE;
            idx            <= '0;
            acc            <= '0;
            bias_q         <= '0;
            result_q       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ovf            <= 1'b0;
            perceptron_out <= 1'b1;
`ifdef AXI_PERCEPTRON_IRQ_EN
            irq_en         <= 1'b0;
            irq            <= 1'b0;
`endif
            // NOTE: the operand arrays are software-visible and must read 0 after reset, so they are flops with reset and not a RAM.
            for (int i = 0; i < N_INPUTS; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignment. Each later statement then sees the pre-edge value, and the last write in program order wins.
            s_axi.awready <= s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid && !s_axi.awready;
            s_axi.wready  <= s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid && !s_axi.awready;
            if (s_axi.bvalid && s_axi.bready) s_axi.bvalid <= 1'b0;

            if (wr_fire) begin
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= RESP_OKAY;
                case (wsel.kind)
                    R_CTRL: begin
                        if (s_axi.wdata[1]) done <= 1'b0;
`ifdef AXI_PERCEPTRON_IRQ_EN
                        irq_en <= s_axi.wdata[2];
`endif
                        if (s_axi.wdata[0] && state == S_IDLE) begin
                            state <= S_MAC;
                            acc   <= {{(ACC_W-32){bias_q[31]}}, bias_q};
                            idx   <= '0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            ovf   <= 1'b0;
                        end
                    end
                    R_BIAS: begin
                        if (busy) s_axi.bresp <= RESP_SLVERR;
                        else      bias_q <= merge(bias_q, s_axi.wdata, s_axi.wstrb);
                    end
                    R_X: begin
                        if (busy) s_axi.bresp <= RESP_SLVERR;
                        else      x_q[widx] <= OW'(merge(sext(x_q[widx]), s_axi.wdata, s_axi.wstrb));
                    end
                    R_W: begin
                        if (busy) s_axi.bresp <= RESP_SLVERR;
                        else      w_q[widx] <= OW'(merge(sext(w_q[widx]), s_axi.wdata, s_axi.wstrb));
                    end
                    R_STATUS, R_RESULT: ;
                    default: s_axi.bresp <= RESP_SLVERR;
                endcase
            end

            case (state)
                S_MAC: begin
                    acc <= acc + {{(ACC_W-2*OW){prod[2*OW-1]}}, prod};
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_INPUTS - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    result_q       <= sat_val;
                    ovf            <= sat_clamp;
                    perceptron_out <= ~sat_val[31];
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    state          <= S_IDLE;
                end
                default: ;
            endcase

`ifdef AXI_PERCEPTRON_IRQ_EN
            irq <= done && irq_en;
`endif
        end
    end

    // Read channel: register a snapshot of the addressed register and hold it until the master accepts it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else begin
            s_axi.arready <= s_axi.arvalid && !s_axi.rvalid && !s_axi.arready;
            if (s_axi.rvalid && s_axi.rready) s_axi.rvalid <= 1'b0;
            if (rd_fire) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rresp  <= RESP_OKAY;
                case (rsel.kind)
`ifdef AXI_PERCEPTRON_IRQ_EN
                    R_CTRL:   s_axi.rdata <= {29'b0, irq_en, 2'b00};
`else
                    R_CTRL:   s_axi.rdata <= '0;
`endif
                    R_STATUS: s_axi.rdata <= {29'b0, ovf, done, busy};
                    R_BIAS:   s_axi.rdata <= bias_q;
                    R_RESULT: s_axi.rdata <= result_q;
                    R_X:      s_axi.rdata <= sext(x_q[ridx]);
                    R_W:      s_axi.rdata <= sext(w_q[ridx]);
                    default: begin
                        s_axi.rdata <= '0;
                        s_axi.rresp <= RESP_SLVERR;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi_perceptron_n.sv
// Directed scoreboard bench for axi_perceptron_n (N_INPUTS=8, OPERAND_WIDTH=16).
// Covers the irq path as well when AXI_PERCEPTRON_IRQ_EN is defined.
module tb_axi_perceptron_n;
    localparam int N     = 8;
    localparam int LIMIT = 60;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_perceptron_n_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
    logic perceptron_out;
`ifdef AXI_PERCEPTRON_IRQ_EN
    logic irq;
`endif

    axi_perceptron_n #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(8),
        .N_INPUTS(N),
        .OPERAND_WIDTH(16)
    ) dut (
        .ACLK(clk),
        .ARESETN(rst_n),
        .s_axi(bus),
        .perceptron_out(perceptron_out)
`ifdef AXI_PERCEPTRON_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int start_cyc = 0;
    int out_fall_cyc = -1;
    int irq_rise_cyc = -1;
    int irq_fall_cyc = -1;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    logic signed [15:0] xs [N];
    logic signed [15:0] ws [N];
    logic signed [31:0] bias_s;

    // Cycle counter plus edge monitors, sampled 1 time unit after each rising edge.
    logic out_prev = 1'b1;
    logic irq_prev = 1'b0;
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (out_prev && !perceptron_out) out_fall_cyc = cyc;
        out_prev = perceptron_out;
`ifdef AXI_PERCEPTRON_IRQ_EN
        if (!irq_prev && irq) irq_rise_cyc = cyc;
        if (irq_prev && !irq) irq_fall_cyc = cyc;
        irq_prev = irq;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $display("FAIL %s observed=timeout required=handshake", tag);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        bus.awaddr  = addr;
        bus.awprot  = 3'b000;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
        if (n >= LIMIT) begin
            timeout_fail("awready_timeout");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        last_hs_cyc = cyc;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
        if (n >= LIMIT) begin
            timeout_fail("bvalid_timeout");
            return;
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x;
        resp = 2'bxx;
        bus.araddr  = addr;
        bus.arprot  = 3'b000;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
        if (n >= LIMIT) begin
            timeout_fail("arready_timeout");
            bus.arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
        if (n >= LIMIT) begin
            timeout_fail("rvalid_timeout");
            return;
        end
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic read_check(input logic [7:0] addr, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp, input string tag);
        exp_t e;
        logic [31:0] d;
        logic [1:0] r;
        e.tag = tag; e.data = exp_data; e.resp = exp_resp;
        sb.push_back(e);
        bus_read(addr, d, r);
        e = sb.pop_front();
        check({e.tag, "_data"}, d, e.data);
        check({e.tag, "_resp"}, {30'b0, r}, {30'b0, e.resp});
    endtask

    task automatic write_check(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input logic [1:0] exp_resp, input string tag);
        exp_t e;
        logic [1:0] r;
        e.tag = tag; e.data = '0; e.resp = exp_resp;
        sb.push_back(e);
        bus_write(addr, data, strb, r);
        e = sb.pop_front();
        check({e.tag, "_bresp"}, {30'b0, r}, {30'b0, e.resp});
    endtask

    task automatic wait_done();
        logic [31:0] s;
        logic [1:0] r;
        int n;
        for (n = 0; n < 30; n++) begin
            bus_read(8'h04, s, r);
            if (s[1] === 1'b1) break;
        end
        if (n >= 30) timeout_fail("done_timeout");
    endtask

    task automatic load_operands();
        for (int i = 0; i < N; i++) begin
            write_check(8'(8'h40 + 4 * i), {{16{xs[i][15]}}, xs[i]}, 4'hF, OKAY, "x_wr");
            write_check(8'(8'h80 + 4 * i), {{16{ws[i][15]}}, ws[i]}, 4'hF, OKAY, "w_wr");
        end
        write_check(8'h08, bias_s, 4'hF, OKAY, "bias_wr");
    endtask

    // Reference: exact 64-bit sum, then clamp to the signed 32-bit range.
    function automatic logic [31:0] model_result(output logic ovf_o);
        longint acc;
        acc = longint'(bias_s);
        for (int i = 0; i < N; i++) acc += longint'(xs[i]) * longint'(ws[i]);
        ovf_o = 1'b0;
        if (acc > 64'sd2147483647) begin
            ovf_o = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (acc < -64'sd2147483648) begin
            ovf_o = 1'b1;
            return 32'h8000_0000;
        end
        return acc[31:0];
    endfunction

    task automatic check_run(input string tag);
        logic [31:0] exp;
        logic ovf_e;
        exp = model_result(ovf_e);
        read_check(8'h0C, exp, OKAY, {tag, "_result"});
        read_check(8'h04, {29'b0, ovf_e, 1'b1, 1'b0}, OKAY, {tag, "_status"});
        check({tag, "_out"}, {31'b0, perceptron_out}, {31'b0, ~exp[31]});
    endtask

    initial begin
        logic [31:0] ctrl_exp;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state.
        check("rst_out", {31'b0, perceptron_out}, 32'd1);
        check("rst_valids", {27'b0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 32'd0);
        read_check(8'h04, 32'h0, OKAY, "rst_status");
        read_check(8'h0C, 32'h0, OKAY, "rst_result");
        read_check(8'h08, 32'h0, OKAY, "rst_bias");
        read_check(8'h40, 32'h0, OKAY, "rst_x0");
        read_check(8'h9C, 32'h0, OKAY, "rst_w7");
        read_check(8'h00, 32'h0, OKAY, "rst_ctrl");

        // Strobes, read-only and unmapped writes, CTRL readback.
        write_check(8'h08, 32'h1122_3344, 4'hF, OKAY, "bias_full");
        write_check(8'h08, 32'hAABB_CCDD, 4'b0101, OKAY, "bias_strb");
        read_check(8'h08, 32'h11BB_33DD, OKAY, "bias_merge");
        write_check(8'h04, 32'hFFFF_FFFF, 4'hF, OKAY, "status_ro_wr");
        read_check(8'h04, 32'h0, OKAY, "status_ro");
        write_check(8'h10, 32'h1, 4'hF, SLVERR, "unmapped_wr");
        write_check(8'h00, 32'h4, 4'hF, OKAY, "ctrl_irqen_wr");
`ifdef AXI_PERCEPTRON_IRQ_EN
        ctrl_exp = 32'h4;
`else
        ctrl_exp = 32'h0;
`endif
        read_check(8'h00, ctrl_exp, OKAY, "ctrl_rd");
        write_check(8'h00, 32'h0, 4'hF, OKAY, "ctrl_clr_wr");

        // X = 1..8, W = 1, BIAS = 0 gives 36.
        for (int i = 0; i < N; i++) begin xs[i] = 16'(i + 1); ws[i] = 16'sd1; end
        bias_s = 32'sd0;
        load_operands();
        write_check(8'h00, 32'h1, 4'hF, OKAY, "start1");
        read_check(8'h04, 32'h1, OKAY, "busy_status");
        wait_done();
        check_run("run_pos");

        // W = -1, BIAS = 5 gives -29. Activation falls exactly 9 cycles after START.
        for (int i = 0; i < N; i++) ws[i] = -16'sd1;
        bias_s = 32'sd5;
        load_operands();
        read_check(8'h80, 32'hFFFF_FFFF, OKAY, "w_sext");
        out_fall_cyc = -1;
        write_check(8'h00, 32'h1, 4'hF, OKAY, "start2");
        start_cyc = last_hs_cyc;
        wait_done();
        check("out_latency", out_fall_cyc - start_cyc, 32'd9);
        check_run("run_neg");

        // Positive overflow. A write while BUSY is rejected, and irq is checked when enabled.
        for (int i = 0; i < N; i++) begin xs[i] = 16'sh7FFF; ws[i] = 16'sh7FFF; end
        bias_s = 32'sh7FFF_FFFF;
        load_operands();
        irq_rise_cyc = -1;
        write_check(8'h00, 32'h5, 4'hF, OKAY, "start3");
        start_cyc = last_hs_cyc;
        write_check(8'h80, 32'h3, 4'hF, SLVERR, "busy_w_wr");
        write_check(8'h00, 32'h5, 4'hF, OKAY, "busy_start");
        wait_done();
        read_check(8'h80, 32'h0000_7FFF, OKAY, "busy_w_kept");
        check_run("run_ovf");
`ifdef AXI_PERCEPTRON_IRQ_EN
        check("irq_latency", irq_rise_cyc - start_cyc, 32'd10);
        check("irq_high", {31'b0, irq}, 32'd1);
`endif
        irq_fall_cyc = -1;
        write_check(8'h00, 32'h6, 4'hF, OKAY, "done_clr");
        read_check(8'h04, 32'h4, OKAY, "done_clr_status");
`ifdef AXI_PERCEPTRON_IRQ_EN
        check("irq_fall", irq_fall_cyc - last_hs_cyc, 32'd1);
        check("irq_low", {31'b0, irq}, 32'd0);
`endif

        // Unmapped reads.
        read_check(8'h3C, 32'h0, SLVERR, "rd_3c");
        read_check(8'hA0, 32'h0, SLVERR, "rd_a0");

        // Reset during MAC, then a clean run.
        write_check(8'h00, 32'h1, 4'hF, OKAY, "start4");
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_out", {31'b0, perceptron_out}, 32'd1);
        read_check(8'h04, 32'h0, OKAY, "midrst_status");
        read_check(8'h0C, 32'h0, OKAY, "midrst_result");
        read_check(8'h08, 32'h0, OKAY, "midrst_bias");
        read_check(8'h40, 32'h0, OKAY, "midrst_x0");
        read_check(8'h80, 32'h0, OKAY, "midrst_w0");
        for (int i = 0; i < N; i++) begin xs[i] = 16'(i + 1); ws[i] = 16'sd1; end
        bias_s = 32'sd0;
        load_operands();
        write_check(8'h00, 32'h1, 4'hF, OKAY, "start5");
        wait_done();
        check_run("run_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_perceptron_n.md
Name: axi_perceptron_n

Overview:
- AXI4-Lite slave perceptron with N_INPUTS parametrised signed inputs, N_INPUTS weights, a bias and a control/status interface.
- Software loads operands over AXI, then writes START. A sequential MAC engine computes bias + sum(x[i]*w[i]) at one term per cycle.
- The result saturates to 32 bits and drives a step-activation output.
- Next-generation replacement for the fixed 4-register perceptron slave. Sits behind the AXI interconnect as a memory-mapped peripheral.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8, AXI byte-address width.
- N_INPUTS, 8, number of input/weight pairs; legal range 1..16.
- OPERAND_WIDTH, 16, signed width of each x and w; legal range 2..16.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- perceptron_out  out  1  step activation: 1 when RESULT >= 0.

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL (W): bit0 START, self-clearing; bit1 DONE_CLR. Reads 0.
  - 0x04 STATUS (R): bit0 BUSY, bit1 DONE, bit2 OVF.
  - 0x08 BIAS (RW): 32-bit signed.
  - 0x0C RESULT (R): 32-bit signed, saturated.
  - 0x40+4i X[i] (RW), for i < N_INPUTS.
  - 0x80+4i W[i] (RW), for i < N_INPUTS.
- X/W storage: low OPERAND_WIDTH bits are stored; reads return the value sign-extended to 32 bits. WSTRB is honoured on BIAS/X/W.
- Reset: all AXI ready/valid outputs are 0; BRESP/RRESP/RDATA are 0; all registers are 0; perceptron_out is 1 (RESULT=0 gives >=0); FSM is in IDLE.
- Write channel:
  - AWREADY and WREADY pulse together for exactly one cycle when AWVALID && WVALID && !BVALID.
  - The register updates on that edge; BVALID rises the next cycle and holds until BREADY.
  - Only one write is outstanding at a time.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID.
  - RDATA/RRESP are registered and RVALID is asserted the following cycle, holding until RREADY.
- Responses:
  - Unmapped address (including X/W offsets >= N_INPUTS): write is dropped, or read returns 0, with resp SLVERR (2'b10).
  - Write to BIAS/X/W while BUSY: dropped, SLVERR.
  - Write to a read-only register: dropped, OKAY.
  - All other accesses: OKAY.
- FSM states: IDLE, MAC, FIN.
  - IDLE -> MAC on an accepted START write. Edge E loads acc = sign-extended BIAS, idx = 0, sets BUSY=1 and clears DONE and OVF.
  - START while BUSY is ignored with OKAY.
  - MAC: each cycle acc += x[idx]*w[idx] and idx++. After the N_INPUTS-th term, go to FIN.
  - FIN (1 cycle): RESULT = saturate(acc) to [0x80000000, 0x7FFFFFFF]; OVF = 1 if clamped; perceptron_out = ~RESULT[31]; BUSY=0; DONE=1. Next state is IDLE.
- Accumulator width: 2*OPERAND_WIDTH + clog2(N_INPUTS) + 33 bits, so no internal wrap.
- Latency: RESULT/STATUS update on edge E + N_INPUTS + 1 (N_INPUTS MAC cycles plus FIN).
- DONE_CLR clears DONE. If DONE_CLR coincides with FIN, FIN wins and DONE=1. START and DONE_CLR in the same write: START takes effect and DONE stays cleared.
- Reset asserted mid-MAC: immediate return to IDLE with every register at its reset value; no partial RESULT is visible.
- A read of STATUS or RESULT on the FIN edge returns the pre-update value.

Optional Feature:
- Macro: AXI_PERCEPTRON_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - CTRL bit2 IRQ_EN (RW, reset 0).
  - irq = DONE && IRQ_EN, registered, so it asserts one cycle after DONE rises.
  - DONE_CLR deasserts irq one cycle after the write is accepted.
- Undefined: no irq port; CTRL bit2 is ignored and reads 0.

Test Plan:
- Reset -> all STATUS/RESULT/X/W/BIAS read 0 with OKAY; perceptron_out=1; no AXI valid asserted.
- X[i]=i+1 (i=0..7), W[i]=1, BIAS=0, START -> BUSY for 9 cycles; RESULT=36 (0x24); DONE=1; OVF=0; out=1.
- Same X, W[i]=0xFFFF (-1), BIAS=5, START -> RESULT=0xFFFFFFE3 (-29); out=0.
- All X=W=0x7FFF, BIAS=0x7FFFFFFF, START -> RESULT=0x7FFFFFFF; OVF=1.
- Write W[0]=3 while BUSY -> BRESP=SLVERR and W[0] is unchanged. Read 0x3C and 0xA0 -> RDATA=0, RRESP=SLVERR.
- ARESETN low at MAC cycle 3 -> all registers 0. A new START after release -> correct RESULT. With AXI_PERCEPTRON_IRQ_EN and IRQ_EN=1: irq rises 1 cycle after DONE and falls after DONE_CLR.
